// File: rtl/lsu_mem_stage_if.sv
// Request/response and data-memory port bundle for the MEM-stage load/store unit.
// The slave modport is the LSU itself; the master modport is the pipeline side
// together with the word-addressed data memory that answers mem_a with mem_rd.
interface lsu_mem_stage_if;
  // pipeline request side
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  // load result and fault reporting
  logic [31:0] rdata;
  logic        rvalid;
  logic        stall;
  logic        fault;
  logic [31:0] fault_addr;
  // data memory side
  logic [31:0] mem_a;
  logic        mem_we;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  modport slave (
    input  req_valid, req_we, funct3, addr, wdata, mem_rd,
    output req_ready, rdata, rvalid, stall, fault, fault_addr,
           mem_a, mem_we, mem_wd
  );

  modport master (
    output req_valid, req_we, funct3, addr, wdata, mem_rd,
    input  req_ready, rdata, rvalid, stall, fault, fault_addr,
           mem_a, mem_we, mem_wd
  );
endinterface

// File: rtl/lsu_mem_stage.sv
// MEM-stage load/store unit for the RV32I pipeline. Turns B/H/W loads and stores
// into word accesses on a word-addressed data memory. Sub-word stores are done as
// a read-modify-write: the merged word is built from mem_rd in the accept cycle
// and written back in the following WRITE cycle, during which the pipeline stalls.
// Misaligned and out-of-range requests never touch memory and raise a fault pulse.
module lsu_mem_stage #(
  parameter int MEM_WORDS = 128
) (
  input  logic           clk,
  input  logic           reset,
  lsu_mem_stage_if.slave bus
);

  typedef enum logic {IDLE, WRITE} state_t;

  localparam logic [29:0] MEM_WORDS_W = 30'(MEM_WORDS);

  state_t      state_reg, state_next;
  logic [31:0] addr_reg;
  logic [31:0] merged_reg;
  logic [31:0] rdata_reg;
  logic        rvalid_reg;
  logic        fault_reg;
  logic [31:0] fault_addr_reg;

  logic        idle;
  logic        f3_legal;
  logic        size_half;
  logic        size_word;
  logic        misaligned;
  logic        out_of_range;
  logic        accept;
  logic        fault_now;
  logic        access;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_ext;
  logic [31:0] merged_word;
  logic        ready_c;
  logic [31:0] mem_a_c;
  logic        mem_we_c;
  logic [31:0] mem_wd_c;

  // Request decode: ready depends only on state, so accept has no path through outputs.
  assign idle         = (state_reg == IDLE);
  assign size_half    = (bus.funct3[1:0] == 2'b01);
  assign size_word    = (bus.funct3[1:0] == 2'b10);
  assign misaligned   = (size_half & bus.addr[0]) | (size_word & (bus.addr[1:0] != 2'b00));
  assign out_of_range = (bus.addr[31:2] >= MEM_WORDS_W);
  assign accept       = bus.req_valid & idle & f3_legal;
  assign fault_now    = accept & (misaligned | out_of_range);
  assign access       = accept & ~fault_now;

  // Legal width codes; the unsigned variants only exist for loads.
  always_comb begin
    f3_legal = 1'b0;
    case (bus.funct3)
      3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
      3'b100, 3'b101:         f3_legal = ~bus.req_we;
      default:                f3_legal = 1'b0;
    endcase
  end

  // Select the addressed byte/half of the read word and extend it per funct3.
  always_comb begin
    byte_lane = bus.mem_rd[7:0];
    case (bus.addr[1:0])
      2'd0: byte_lane = bus.mem_rd[7:0];
      2'd1: byte_lane = bus.mem_rd[15:8];
      2'd2: byte_lane = bus.mem_rd[23:16];
      2'd3: byte_lane = bus.mem_rd[31:24];
      default: byte_lane = bus.mem_rd[7:0];
    endcase
    half_lane = bus.addr[1] ? bus.mem_rd[31:16] : bus.mem_rd[15:0];
    case (bus.funct3)
      3'b000:  load_ext = {{24{byte_lane[7]}}, byte_lane};
      3'b100:  load_ext = {24'h0, byte_lane};
      3'b001:  load_ext = {{16{half_lane[15]}}, half_lane};
      3'b101:  load_ext = {16'h0, half_lane};
      default: load_ext = bus.mem_rd;
    endcase
  end

  // Build the read-modify-write word: current memory word with one lane replaced.
  always_comb begin
    merged_word = bus.mem_rd;
    if (size_half) begin
      if (bus.addr[1]) merged_word[31:16] = bus.wdata[15:0];
      else             merged_word[15:0]  = bus.wdata[15:0];
    end else begin
      case (bus.addr[1:0])
        2'd0: merged_word[7:0]   = bus.wdata[7:0];
        2'd1: merged_word[15:8]  = bus.wdata[7:0];
        2'd2: merged_word[23:16] = bus.wdata[7:0];
        2'd3: merged_word[31:24] = bus.wdata[7:0];
        default: merged_word = bus.mem_rd;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // FSM next state and memory-port outputs; mem_we is forced low while reset is high
  // so a pending RMW write is dropped immediately.
  always_comb begin
    state_next = state_reg;
    ready_c    = 1'b0;
    mem_a_c    = bus.addr;
    mem_we_c   = 1'b0;
    mem_wd_c   = bus.wdata;
    case (state_reg)
      IDLE: begin
        ready_c = 1'b1;
        if (access && bus.req_we) begin
          if (size_word) mem_we_c   = 1'b1;
          else           state_next = WRITE;
        end
      end
      WRITE: begin
        mem_a_c    = addr_reg;
        mem_we_c   = 1'b1;
        mem_wd_c   = merged_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    mem_we_c = mem_we_c & ~reset;
  end

  // Registered load result, fault report and RMW bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_reg       <= 32'h0;
      merged_reg     <= 32'h0;
      rdata_reg      <= 32'h0;
      rvalid_reg     <= 1'b0;
      fault_reg      <= 1'b0;
      fault_addr_reg <= 32'h0;
    end else begin
      rvalid_reg <= access & ~bus.req_we;
      fault_reg  <= fault_now;
      if (access && !bus.req_we) rdata_reg <= load_ext;
      if (fault_now) fault_addr_reg <= bus.addr;
      if (access && bus.req_we && !size_word) begin
        addr_reg   <= bus.addr;
        merged_reg <= merged_word;
      end
    end
  end

  assign bus.req_ready  = ready_c;
  assign bus.stall      = ~ready_c;
  assign bus.mem_a      = mem_a_c;
  assign bus.mem_we     = mem_we_c;
  assign bus.mem_wd     = mem_wd_c;
  assign bus.rdata      = rdata_reg;
  assign bus.rvalid     = rvalid_reg;
  assign bus.fault      = fault_reg;
  assign bus.fault_addr = fault_addr_reg;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Scoreboard bench for lsu_mem_stage: expected load results, faults and memory
// writes are queued with the cycle they must appear in, and a negedge monitor
// pops and compares them as the DUT produces them.
module tb_lsu_mem_stage;

  localparam int MW = 128;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  logic [31:0] mem [0:MW-1];
  exp_t rd_q[$];
  exp_t flt_q[$];
  exp_t wr_q[$];
  exp_t m_rd, m_flt, m_wr;

  lsu_mem_stage_if bus ();

  lsu_mem_stage #(.MEM_WORDS(MW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // cycle counter used to check result latency
  always @(posedge clk) cyc <= cyc + 1;

  // data memory model: combinational read, write on the clock edge
  assign bus.mem_rd = (bus.mem_a[31:9] == 23'h0) ? mem[bus.mem_a[8:2]] : 32'h0;
  always @(posedge clk) begin
    if (bus.mem_we && bus.mem_a[31:9] == 23'h0) mem[bus.mem_a[8:2]] <= bus.mem_wd;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // monitor: every DUT response must match the head of its queue, in the right cycle
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.rvalid) begin
        if (rd_q.size() == 0) chk("rvalid_spurious", 32'd1, 32'd0);
        else begin
          m_rd = rd_q.pop_front();
          chk("rdata", bus.rdata, m_rd.d);
          chk("rvalid_cycle", 32'(cyc), 32'(m_rd.cyc));
        end
      end
      if (bus.fault) begin
        if (flt_q.size() == 0) chk("fault_spurious", 32'd1, 32'd0);
        else begin
          m_flt = flt_q.pop_front();
          chk("fault_addr", bus.fault_addr, m_flt.a);
          chk("fault_cycle", 32'(cyc), 32'(m_flt.cyc));
          chk("fault_no_rvalid", 32'(bus.rvalid), 32'd0);
        end
      end
      if (bus.mem_we) begin
        if (wr_q.size() == 0) chk("mem_we_spurious", 32'd1, 32'd0);
        else begin
          m_wr = wr_q.pop_front();
          chk("mem_word_addr", {2'b00, bus.mem_a[31:2]}, {2'b00, m_wr.a[31:2]});
          chk("mem_wd", bus.mem_wd, m_wr.d);
          chk("mem_we_cycle", 32'(cyc), 32'(m_wr.cyc));
        end
      end
    end
  end

  // kind: 0 load result, 1 fault, 2 word store, 3 sub-word RMW store, 4 no response
  // Called at posedge+1; returns at posedge+1 of the cycle after acceptance with the
  // request still driven (call idle() to drop it).
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int kind, input logic [31:0] exp);
    int waited;
    waited = 0;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.funct3    = f3;
    bus.addr      = a;
    bus.wdata     = wd;
    #1;
    while (!bus.req_ready && waited < 20) begin
      @(posedge clk);
      #2;
      waited++;
    end
    if (!bus.req_ready) begin
      chk("ready_timeout", 32'd0, 32'd1);
      bus.req_valid = 1'b0;
      return;
    end
    case (kind)
      0: rd_q.push_back('{a, exp, cyc + 1});
      1: flt_q.push_back('{a, 32'h0, cyc + 1});
      2: begin
        wr_q.push_back('{a, exp, cyc});
        chk("sw_we_same_cycle", 32'(bus.mem_we), 32'd1);
        chk("sw_no_stall", 32'(bus.stall), 32'd0);
      end
      3: begin
        wr_q.push_back('{a, exp, cyc + 1});
        chk("rmw_first_we", 32'(bus.mem_we), 32'd0);
        chk("rmw_first_stall", 32'(bus.stall), 32'd0);
      end
      default: ;
    endcase
    if (kind == 1) chk("fault_no_we", 32'(bus.mem_we), 32'd0);
    @(posedge clk);
    #1;
    if (kind == 3) chk("rmw_write_stall", 32'(bus.stall), 32'd1);
  endtask

  task automatic idle(input int n);
    bus.req_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    for (int i = 0; i < MW; i++) mem[i] = 32'h0;
    mem[4]   = 32'h8899AABB;
    mem[127] = 32'hCAFEF00D;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.funct3    = 3'b000;
    bus.addr      = 32'h0;
    bus.wdata     = 32'h0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
    chk("rst_fault", 32'(bus.fault), 32'd0);
    chk("rst_fault_addr", bus.fault_addr, 32'h0);
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    reset = 1'b0;
    idle(1);

    // loads, back to back
    do_req(1'b0, 3'b000, 32'h13, 32'h0, 0, 32'hFFFFFF88);
    do_req(1'b0, 3'b100, 32'h12, 32'h0, 0, 32'h00000099);
    do_req(1'b0, 3'b001, 32'h10, 32'h0, 0, 32'hFFFFAABB);
    do_req(1'b0, 3'b101, 32'h12, 32'h0, 0, 32'h00008899);
    do_req(1'b0, 3'b010, 32'h10, 32'h0, 0, 32'h8899AABB);
    idle(2);

    // SB then a load held off by the WRITE cycle
    do_req(1'b1, 3'b000, 32'h11, 32'h123456CC, 3, 32'h8899CCBB);
    do_req(1'b0, 3'b010, 32'h10, 32'h0, 0, 32'h8899CCBB);
    idle(2);

    // SW, SH on top of it, read back
    do_req(1'b1, 3'b010, 32'h20, 32'hDEADBEEF, 2, 32'hDEADBEEF);
    do_req(1'b1, 3'b001, 32'h22, 32'h00001234, 3, 32'h1234BEEF);
    do_req(1'b0, 3'b010, 32'h20, 32'h0, 0, 32'h1234BEEF);
    idle(2);

    // faults, last in-range word, illegal codes
    do_req(1'b0, 3'b010, 32'h22, 32'h0, 1, 32'h0);
    do_req(1'b1, 3'b010, 32'h200, 32'h11111111, 1, 32'h0);
    do_req(1'b0, 3'b001, 32'h13, 32'h0, 1, 32'h0);
    do_req(1'b0, 3'b010, 32'h203, 32'h0, 1, 32'h0);
    do_req(1'b0, 3'b010, 32'h1FC, 32'h0, 0, 32'hCAFEF00D);
    do_req(1'b0, 3'b011, 32'h10, 32'h0, 4, 32'h0);
    do_req(1'b1, 3'b100, 32'h10, 32'hFFFFFFFF, 4, 32'h0);
    idle(3);
    chk("mem_word4", mem[4], 32'h8899CCBB);
    chk("mem_word8", mem[8], 32'h1234BEEF);

    // reset during the WRITE cycle of an SH drops the write
    do_req(1'b1, 3'b001, 32'h22, 32'h00005555, 4, 32'h0);
    bus.req_valid = 1'b0;
    chk("rmw_write_we", 32'(bus.mem_we), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_drop_we", 32'(bus.mem_we), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_drop_mem", mem[8], 32'h1234BEEF);
    chk("rst_drop_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_drop_rvalid", 32'(bus.rvalid), 32'd0);
    chk("rst_drop_fault", 32'(bus.fault), 32'd0);
    @(posedge clk);
    #1;
    do_req(1'b0, 3'b010, 32'h20, 32'h0, 0, 32'h1234BEEF);
    idle(3);

    chk("rd_q_drained", 32'(rd_q.size()), 32'd0);
    chk("flt_q_drained", 32'(flt_q.size()), 32'd0);
    chk("wr_q_drained", 32'(wr_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Load/store unit for the MEM stage of the pipelined RV32I core, sitting directly upstream of the word-addressed data memory.
- Converts byte, halfword and word loads and stores into word accesses on the memory port. Byte and halfword stores use a two-cycle read-modify-write.
- Aligns and sign- or zero-extends load data into a registered result.
- Flags misaligned and out-of-range accesses without touching memory.

Parameters:
- MEM_WORDS, 128, number of 32-bit words in data memory; word index addr[31:2] >= MEM_WORDS is out of range.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  memory request present this cycle
- req_ready  output  1  request accepted when req_valid & req_ready
- req_we  input  1  1 = store, 0 = load
- funct3  input  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  input  32  byte address
- wdata  input  32  store data; low byte or half is used for SB/SH
- mem_a  output  32  address to data memory
- mem_we  output  1  data memory write enable
- mem_wd  output  32  data memory write word
- mem_rd  input  32  data memory read word (combinational from mem_a)
- rdata  output  32  extended load result (registered)
- rvalid  output  1  rdata valid, one-cycle pulse
- stall  output  1  equals ~req_ready, drives pipeline hold
- fault  output  1  one-cycle pulse for a misaligned or out-of-range request
- fault_addr  output  32  address of the last faulting request

Behaviour:
- Reset (async) state: FSM = IDLE; rdata = 0, rvalid = 0, fault = 0, fault_addr = 0. mem_we = 0 immediately, because it is decoded from state and request.
- FSM states:
  - IDLE: req_ready = 1.
  - WRITE: req_ready = 0.
- Accept = req_valid & req_ready & legal funct3.
- Illegal funct3 (011/110/111, or 1xx with req_we = 1): request is consumed; no access, no response, no fault.
- Misaligned:
  - H/HU/SH with addr[0] = 1.
  - W/SW with addr[1:0] != 0.
- Out of range: addr[31:2] >= MEM_WORDS.
- Fault case:
  - mem_we = 0; no FSM change.
  - Next cycle: fault = 1 and fault_addr = addr; rvalid = 0.
  - Misaligned takes priority over out-of-range; both report the same single fault.
- mem_a = addr in IDLE; in WRITE, mem_a = latched address.
- Load, accepted in cycle N:
  - Lane select: byte = mem_rd[8*addr[1:0] +: 8], half = mem_rd[16*addr[1] +: 16].
  - Extension: B/H sign-extend, BU/HU zero-extend, W passes through.
  - Result registered at the end of N; rvalid = 1 in N+1 only.
  - Back-to-back loads give one result per cycle.
- SW, accepted in cycle N: mem_we = 1 and mem_wd = wdata in cycle N; single cycle; state stays IDLE.
- SB/SH (RMW):
  - Cycle N (IDLE, accept): mem_we = 0. Register the merged word: mem_rd with the byte/half lane replaced by wdata[7:0] or wdata[15:0]. Latch the address. Go to WRITE.
  - Cycle N+1 (WRITE): mem_we = 1, mem_wd = merged word. Return to IDLE.
  - stall = 1 only during N+1.
- Requests presented during WRITE are not accepted; the requester holds them until req_ready = 1.
- Reset asserted during WRITE: the write is dropped (mem_we falls asynchronously) and memory is unchanged.
- Store does not assert rvalid.
- The memory-side write takes effect at the clk edge ending the mem_we cycle. A load in the next cycle observes the new data; no internal forwarding is required.

Test Plan:
- Memory word 0x00000010 = 0x8899AABB; LB addr 0x13 -> rvalid next cycle, rdata = 0xFFFFFF88; LBU addr 0x12 -> rdata = 0x00000099.
- Same word; LH addr 0x10 -> 0xFFFFAABB; LHU addr 0x12 -> 0x00008899; LW addr 0x10 -> 0x8899AABB; issued back to back -> three consecutive rvalid pulses.
- SB addr 0x11, wdata 0x123456CC -> cycle 1 mem_we = 0, cycle 2 mem_we = 1 with mem_wd = 0x8899CCBB and stall = 1; following LW addr 0x10 returns 0x8899CCBB.
- SW addr 0x20, wdata 0xDEADBEEF -> mem_we = 1 in the same cycle, stall stays 0; then SH addr 0x22, wdata 0x00001234 -> word becomes 0x1234BEEF.
- LW addr 0x22 -> fault = 1 next cycle, fault_addr = 0x22, rvalid = 0; SW addr 0x200 with MEM_WORDS = 128 -> fault, mem_we never asserted, memory unchanged.
- SH accepted, then reset asserted during WRITE -> mem_we = 0 at once, target word unchanged, rvalid = 0, fault = 0, req_ready = 1 after reset release.
